// File: rtl/irq_source_conditioner.sv
// Per-source interrupt conditioner: edge/level detect, enable gating and holdoff coalescing into one-cycle strobes.
// Optional macro IRQ_SRC_SYNC_EN inserts a 2-flop synchronizer on SRC_IN (latency 3 instead of 1).
module irq_source_conditioner #(
  parameter int IRQ_COUNT     = 4,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IRQ_COUNT-1:0]     SRC_IN,
  input  logic [IRQ_COUNT-1:0]     SRC_ENABLE,
  input  logic [IRQ_COUNT-1:0]     EDGE_SEL,
  input  logic [HOLDOFF_WIDTH-1:0] HOLDOFF_CYCLES,
  output logic [IRQ_COUNT-1:0]     IRQ_OUT,
  output logic [IRQ_COUNT-1:0]     HOLD_BUSY
);

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_HOLD,
    PH_EXPIRE
  } phase_e;

  localparam logic [HOLDOFF_WIDTH-1:0] TMR_ONE = HOLDOFF_WIDTH'(1);

  logic [IRQ_COUNT-1:0] src_s;
  logic [IRQ_COUNT-1:0] src_dly_q;

`ifdef IRQ_SRC_SYNC_EN
  logic [IRQ_COUNT-1:0] sync1_q;
  logic [IRQ_COUNT-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SRC_IN;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = SRC_IN;
`endif

  // Delayed copy tracks the input even while disabled, so re-enabling a high input is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_dly_q <= '0;
    end else begin
      src_dly_q <= src_s;
    end
  end

  for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_src
    logic [HOLDOFF_WIDTH-1:0] tmr_q;
    logic [HOLDOFF_WIDTH-1:0] tmr_d;
    logic                     pend_q;
    logic                     pend_d;
    logic                     strobe_q;
    logic                     strobe_d;
    logic                     busy_q;
    logic                     evt;
    phase_e                   phase;

    assign evt = SRC_ENABLE[gi] &
                 (EDGE_SEL[gi] ? (src_s[gi] & ~src_dly_q[gi]) : src_s[gi]);

    always_comb begin
      if (tmr_q == '0) begin
        phase = PH_IDLE;
      end else if (tmr_q == TMR_ONE) begin
        phase = PH_EXPIRE;
      end else begin
        phase = PH_HOLD;
      end
    end

    always_comb begin
      tmr_d    = tmr_q;
      pend_d   = pend_q;
      strobe_d = 1'b0;
      if (!SRC_ENABLE[gi]) begin
        tmr_d  = '0;
        pend_d = 1'b0;
      end else begin
        unique case (phase)
          PH_IDLE: begin
            if (evt) begin
              strobe_d = 1'b1;
              tmr_d    = HOLDOFF_CYCLES;
              pend_d   = 1'b0;
            end
          end
          PH_HOLD: begin
            tmr_d = tmr_q - TMR_ONE;
            if (evt) begin
              pend_d = 1'b1;
            end
          end
          PH_EXPIRE: begin
            // Anything seen during the window collapses into this single strobe.
            if (pend_q || evt) begin
              strobe_d = 1'b1;
              tmr_d    = HOLDOFF_CYCLES;
            end else begin
              tmr_d = '0;
            end
            pend_d = 1'b0;
          end
          default: begin
            tmr_d  = '0;
            pend_d = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        tmr_q    <= '0;
        pend_q   <= 1'b0;
        strobe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        tmr_q    <= tmr_d;
        pend_q   <= pend_d;
        strobe_q <= strobe_d;
        busy_q   <= (tmr_d != '0);
      end
    end

    assign IRQ_OUT[gi]   = strobe_q;
    assign HOLD_BUSY[gi] = busy_q;
  end

endmodule

// File: tb/tb_irq_source_conditioner.sv
// Testbench for irq_source_conditioner: vector table, directed multi-cycle cases and a
// randomized run against a cycle-window reference model (honours IRQ_SRC_SYNC_EN).
module tb_irq_source_conditioner;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] src;
  logic [N-1:0] en;
  logic [N-1:0] edg;
  logic [W-1:0] hold;
  logic [N-1:0] irq;
  logic [N-1:0] busy;

  int checks = 0;
  int errors = 0;

  irq_source_conditioner #(.IRQ_COUNT(N), .HOLDOFF_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .SRC_IN         (src),
    .SRC_ENABLE     (en),
    .EDGE_SEL       (edg),
    .HOLDOFF_CYCLES (hold),
    .IRQ_OUT        (irq),
    .HOLD_BUSY      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] src;
    logic [N-1:0] edg;
    logic [W-1:0] hold;
    logic [N-1:0] irq;
    logic [N-1:0] busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [N-1:0] s, input logic [N-1:0] e, input logic [W-1:0] h,
                              input logic [N-1:0] i, input logic [N-1:0] b);
    vec_t v;
    v.src = s; v.edg = e; v.hold = h; v.irq = i; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; src = '0; en = '1; edg = '1; hold = '0;
    step();
    chk("reset_irq", irq, '0);
    chk("reset_busy", busy, '0);
    reset = 1'b0;
  endtask

  // Reference model: holdoff expressed as an absolute window of event cycles [start, win_end).
  int           win_end[N];
  bit           pend[N];
  bit           prev[N];
  logic [N-1:0] sp1, sp2;
  int           mcyc;
  logic [N-1:0] exp_irq, exp_busy;

  task automatic model_step();
    logic [N-1:0] s;
    bit ev, fire;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        win_end[k] = 0; pend[k] = 0; prev[k] = 0;
      end
      sp1 = '0; sp2 = '0; exp_irq = '0; exp_busy = '0;
    end else begin
`ifdef IRQ_SRC_SYNC_EN
      s = sp2;
`else
      s = src;
`endif
      for (int k = 0; k < N; k++) begin
        ev = en[k] && (edg[k] ? (s[k] && !prev[k]) : s[k]);
        prev[k] = s[k];
        fire = 0;
        if (!en[k]) begin
          win_end[k] = 0; pend[k] = 0;
        end else if (mcyc < win_end[k]) begin
          if (ev) pend[k] = 1;
          if (mcyc == win_end[k] - 1 && pend[k]) fire = 1;
        end else begin
          fire = ev;
        end
        if (fire) begin
          win_end[k] = mcyc + 1 + int'(hold);
          pend[k] = 0;
        end
        exp_irq[k]  = fire;
        exp_busy[k] = (mcyc + 1 < win_end[k]);
      end
      sp2 = sp1; sp1 = src;
    end
    mcyc++;
  endtask

  initial begin
    logic [N-1:0] seen;
    int hsel;
    reset = 1'b1; src = '0; en = '1; edg = '1; hold = '0;
    mcyc = 0; sp1 = '0; sp2 = '0;
    step();
    do_reset();

`ifndef IRQ_SRC_SYNC_EN
    // Edge pulse with no holdoff, then a 5-cycle level burst, then edge coalescing with holdoff 8.
    add(4'b0001, 4'b1111, 16'd0, 4'b0001, 4'b0000);
    add(4'b0000, 4'b1111, 16'd0, 4'b0000, 4'b0000);
    add(4'b0000, 4'b1111, 16'd0, 4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) add(4'b0010, 4'b1101, 16'd0, 4'b0010, 4'b0000);
    add(4'b0000, 4'b1101, 16'd0, 4'b0000, 4'b0000);
    for (int c = 0; c < 18; c++) begin
      logic [N-1:0] s_c, i_c, b_c;
      s_c = (c <= 6 && c % 2 == 0) ? 4'b0001 : 4'b0000;
      i_c = (c == 0 || c == 8) ? 4'b0001 : 4'b0000;
      b_c = (c <= 15) ? 4'b0001 : 4'b0000;
      add(s_c, 4'b1111, 16'd8, i_c, b_c);
    end
    foreach (vecs[r]) begin
      src = vecs[r].src; edg = vecs[r].edg; hold = vecs[r].hold;
      step();
      $display("row %0d src=%b irq=%b busy=%b", r, src, irq, busy);
      chk($sformatf("row%0d_irq", r), irq, vecs[r].irq);
      chk($sformatf("row%0d_busy", r), busy, vecs[r].busy);
    end

    // Stuck-high level source, holdoff 4: strobes every 4 cycles.
    do_reset();
    edg = 4'b1011; hold = 16'd4; src = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("stuck_c%0d", i + 1), irq, (i % 4 == 0) ? 4'b0100 : 4'b0000);
    end
    $display("stuck-high level source sequence done");

    // Disable while pending: no expiry strobe, busy drops.
    do_reset();
    hold = 16'd8;
    src = 4'b0001; step(); chk("dis_first", irq, 4'b0001);
    src = 4'b0000; step(); chk("dis_busy", busy, 4'b0001);
    src = 4'b0001; step();
    src = 4'b0000; en = 4'b1110; step();
    chk("dis_busy_off", busy, 4'b0000);
    en = 4'b1111;
    seen = '0;
    for (int i = 0; i < 12; i++) begin step(); seen |= irq | busy; end
    chk("dis_no_strobe", seen, 4'b0000);
    $display("disable-while-pending sequence done");

    // Reset while pending: all outputs cleared, no strobe afterwards.
    do_reset();
    hold = 16'd8;
    src = 4'b0001; step(); chk("rst_first", irq, 4'b0001);
    src = 4'b0000; step();
    src = 4'b0001; step();
    src = 4'b0000; reset = 1'b1; step();
    chk("rst_irq", irq, 4'b0000);
    chk("rst_busy", busy, 4'b0000);
    reset = 1'b0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin step(); seen |= irq | busy; end
    chk("rst_no_strobe", seen, 4'b0000);
    $display("reset-while-pending sequence done");

    // Edge source high through reset counts as one edge; re-enable while high is not an edge.
    reset = 1'b1; src = 4'b0001; edg = '1; en = '1; hold = '0;
    step();
    reset = 1'b0; step(); chk("post_reset_edge", irq, 4'b0001);
    step(); chk("post_reset_hold_high", irq, 4'b0000);
    en = 4'b1110; step(); step();
    en = 4'b1111; step(); chk("reenable_high", irq, 4'b0000);
    $display("reset-edge and re-enable sequence done");

    // Holdoff value is captured only at load.
    do_reset();
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      src  = (i == 0 || i == 2) ? 4'b0001 : 4'b0000;
      hold = (i == 0) ? 16'd6 : 16'd2;
      step();
      chk($sformatf("hchg_irq_%0d", i), irq, (i == 0 || i == 6) ? 4'b0001 : 4'b0000);
      if (i == 7) chk("hchg_busy_7", busy, 4'b0001);
      if (i == 8) chk("hchg_busy_8", busy, 4'b0000);
    end
    $display("holdoff-capture sequence done");
`else
    // Synchronizer latency: pulse in cycle 10 appears in cycle 13.
    do_reset();
    hold = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i == 10) ? 4'b0001 : 4'b0000;
      step();
      chk($sformatf("sync_c%0d", i + 1), irq, (i == 12) ? 4'b0001 : 4'b0000);
    end
    $display("synchronizer latency sequence done");
`endif

    // Randomized run against the reference model.
    hold = '0; edg = '1; en = '1;
    for (int n = 0; n < 3000; n++) begin
      reset = (n == 0) || ($urandom_range(199) == 0);
      if (n % 60 == 0) begin
        hsel = $urandom_range(5);
        hold = (hsel == 5) ? 16'd7 : W'(hsel);
      end
      if (n % 97 == 0) edg = N'($urandom);
      for (int k = 0; k < N; k++) en[k] = ($urandom_range(9) != 0);
      src = (n % 400 < 200) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      model_step();
      step();
      chk($sformatf("rand%0d_irq", n), irq, exp_irq);
      chk($sformatf("rand%0d_busy", n), busy, exp_busy);
    end
    $display("random run of 3000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
